// File: rtl/uart_frame_packer_if.sv
// Handshake bundle between the packer and its neighbours: the user payload
// stream coming in and the UART DMA send stream going out.
// Signal names follow the packer's point of view (i_ = into the packer).
interface uart_frame_packer_if;
    logic [7:0] i_usr_cmd;
    logic [7:0] i_usr_data;
    logic       i_usr_valid;
    logic       i_usr_last;
    logic       o_usr_ready;

    logic [7:0] o_uart_DMA_tdata;
    logic       o_uart_DMA_tvalid;
    logic       o_uart_DMA_tlast;
    logic       i_uart_DMA_tready;

    // Packer side
    modport slave (
        input  i_usr_cmd,
        input  i_usr_data,
        input  i_usr_valid,
        input  i_usr_last,
        output o_usr_ready,
        output o_uart_DMA_tdata,
        output o_uart_DMA_tvalid,
        output o_uart_DMA_tlast,
        input  i_uart_DMA_tready
    );

    // Environment side: payload source and UART DMA sink
    modport master (
        output i_usr_cmd,
        output i_usr_data,
        output i_usr_valid,
        output i_usr_last,
        input  o_usr_ready,
        input  o_uart_DMA_tdata,
        input  o_uart_DMA_tvalid,
        input  o_uart_DMA_tlast,
        output i_uart_DMA_tready
    );
endinterface

// File: rtl/uart_frame_packer.sv
// Transmit-side frame builder for the UART DMA path.
// Collects one payload packet, then emits HEAD_BYTE, cmd, len, payload.
// Optional checksum trailer: define UART_FRAME_CSUM_EN. The trailer is the
// 8-bit sum of cmd, the length field and the payload, the length field then
// counts the trailer, and the stored payload is limited to MAX_LEN-1 bytes
// (MAX_LEN must then be at least 2).
//
// state   | meaning
// IDLE    | waiting for the first payload beat
// LOAD    | storing payload beats into the buffer
// DRAIN   | buffer full, discarding beats up to the one marked last
// HDR     | HEAD_BYTE presented on the send stream
// CMD     | command byte presented
// LEN     | length field presented
// PLD     | payload bytes presented from the buffer
// CSUM    | checksum byte presented (checksum build only)
// DONE    | one-cycle frame_done pulse, then back to IDLE
module uart_frame_packer #(
    parameter logic [7:0]  HEAD_BYTE = 8'h55,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    uart_frame_packer_if.slave    bus,
    output logic                  o_frame_done,
    output logic                  o_overflow_err
);

`ifdef UART_FRAME_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    // One buffer slot is given up to the checksum byte when it is enabled
    localparam int unsigned LIMIT   = CSUM_EN ? MAX_LEN - 1 : MAX_LEN;
    localparam logic [7:0]  LIMIT_B = 8'(LIMIT);
    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HDR,
        S_CMD,
        S_LEN,
        S_PLD,
        S_CSUM,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_cnt;
    logic [7:0] r_idx;
    logic [7:0] r_tdata;
    logic       r_tvalid;
    logic       r_tlast;
    logic       r_usr_ready;
    logic       r_frame_done;
    logic       r_overflow_err;
    logic [7:0] r_buf [MAX_LEN];

    logic       w_beat;
    logic       w_xfer;
    logic       w_wr_en;
    logic [7:0] w_wr_idx;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_rd_byte;
    logic [7:0] w_len_field;
    logic [7:0] w_csum;
    logic       w_pld_last;

    assign w_beat      = bus.i_usr_valid & r_usr_ready;
    assign w_xfer      = r_tvalid & bus.i_uart_DMA_tready;
    assign w_wr_en     = w_beat & ((r_state == S_IDLE) | (r_state == S_LOAD));
    assign w_wr_idx    = (r_state == S_IDLE) ? 8'd0 : r_cnt;
    assign w_cnt_nxt   = w_wr_idx + 8'd1;
    assign w_len_field = CSUM_EN ? r_cnt + 8'd1 : r_cnt;

    // Combinational read keeps the payload streaming at one byte per cycle
    assign w_rd_byte   = r_buf[r_idx[AW-1:0]];

    // With the trailer enabled the last payload byte is never the frame end
    assign w_pld_last  = !CSUM_EN && (r_idx == r_cnt - 8'd1);

`ifdef UART_FRAME_CSUM_EN
    logic [7:0] r_psum;

    // Running sum of stored payload bytes; discarded overflow beats are not
    // part of the frame and so are not summed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psum <= 8'd0;
        end else if (w_wr_en) begin
            r_psum <= (r_state == S_IDLE) ? bus.i_usr_data : r_psum + bus.i_usr_data;
        end
    end

    assign w_csum = r_cmd + w_len_field + r_psum;
`else
    assign w_csum = 8'h00;
`endif

    // Payload buffer; contents are don't-care after reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx[AW-1:0]] <= bus.i_usr_data;
        end
    end

    // Frame sequencing with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cmd          <= 8'd0;
            r_cnt          <= 8'd0;
            r_idx          <= 8'd0;
            r_tdata        <= 8'd0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_usr_ready    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_overflow_err <= 1'b0;

            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_usr_ready <= 1'b1;
                    r_idx       <= 8'd0;
                    if (w_beat) begin
                        if (r_state == S_IDLE) begin
                            r_cmd <= bus.i_usr_cmd;
                        end
                        r_cnt <= w_cnt_nxt;
                        if (bus.i_usr_last) begin
                            r_state     <= S_HDR;
                            r_usr_ready <= 1'b0;
                            r_tvalid    <= 1'b1;
                            r_tdata     <= HEAD_BYTE;
                            r_tlast     <= 1'b0;
                        end else if (w_cnt_nxt == LIMIT_B) begin
                            r_state        <= S_DRAIN;
                            r_overflow_err <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end

                S_DRAIN: begin
                    r_usr_ready <= 1'b1;
                    if (w_beat && bus.i_usr_last) begin
                        r_state     <= S_HDR;
                        r_usr_ready <= 1'b0;
                        r_tvalid    <= 1'b1;
                        r_tdata     <= HEAD_BYTE;
                        r_tlast     <= 1'b0;
                    end
                end

                S_HDR: begin
                    if (w_xfer) begin
                        r_tdata <= r_cmd;
                        r_state <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (w_xfer) begin
                        r_tdata <= w_len_field;
                        r_state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (w_xfer) begin
                        r_tdata <= w_rd_byte;
                        r_tlast <= w_pld_last;
                        r_idx   <= 8'd1;
                        r_state <= S_PLD;
                    end
                end

                S_PLD: begin
                    if (w_xfer) begin
                        if (r_idx == r_cnt) begin
                            if (CSUM_EN) begin
                                r_tdata <= w_csum;
                                r_tlast <= 1'b1;
                                r_state <= S_CSUM;
                            end else begin
                                r_tvalid     <= 1'b0;
                                r_tlast      <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= S_DONE;
                            end
                        end else begin
                            r_tdata <= w_rd_byte;
                            r_tlast <= w_pld_last;
                            r_idx   <= r_idx + 8'd1;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_xfer) begin
                        r_tvalid     <= 1'b0;
                        r_tlast      <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_usr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_tvalid    <= 1'b0;
                    r_tlast     <= 1'b0;
                    r_usr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_usr_ready       = r_usr_ready;
    assign bus.o_uart_DMA_tdata  = r_tdata;
    assign bus.o_uart_DMA_tvalid = r_tvalid;
    assign bus.o_uart_DMA_tlast  = r_tlast;
    assign o_frame_done          = r_frame_done;
    assign o_overflow_err        = r_overflow_err;

endmodule

// File: doc/uart_frame_packer.md
Name: uart_frame_packer

Overview:
- Transmit-side frame builder for the UART DMA path.
- Accepts one variable-length payload packet from a user byte stream, stores it, then emits one framed packet on the UART DMA send stream: HEAD_BYTE, command byte, length byte, payload bytes.
- The frame layout matches what the UART DMA receive framer parses: it counts 3 + length bytes after the header.
- Sits between the control/register logic and the UART DMA send interface.

Parameters:
- HEAD_BYTE, 8'h55, first byte of every frame.
- MAX_LEN, 255, maximum payload bytes per frame (1..255); the buffer depth is MAX_LEN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_usr_cmd  in  8  command byte; sampled on the first accepted payload beat.
- i_usr_data  in  8  payload byte.
- i_usr_valid  in  1  payload beat valid.
- i_usr_last  in  1  last payload beat of the packet.
- o_usr_ready  out  1  block can accept a payload beat.
- o_uart_DMA_tdata  out  8  frame byte to the UART DMA send stream.
- o_uart_DMA_tvalid  out  1  frame byte valid.
- o_uart_DMA_tlast  out  1  final byte of the frame.
- i_uart_DMA_tready  in  1  downstream accepts a byte.
- o_frame_done  out  1  one-cycle pulse after the final frame byte transfers.
- o_overflow_err  out  1  one-cycle pulse when a packet is truncated at MAX_LEN.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, buffer contents don't-care. All outputs 0, except o_usr_ready = 1 one cycle after reset release.
- A reset asserted mid-frame abandons the frame; tvalid drops immediately and no tlast or done pulse is produced.
- Beat accepted = i_usr_valid & o_usr_ready. Byte transferred = o_uart_DMA_tvalid & i_uart_DMA_tready.
- FSM states:
  - IDLE: o_usr_ready=1. The first accepted beat latches cmd, writes buffer[0], sets cnt=1, goes to LOAD. If that beat also has last=1, go straight to HDR.
  - LOAD: each accepted beat writes buffer[cnt] and increments cnt.
    - On last=1: go to HDR; len=cnt (8-bit, including that beat).
    - On cnt reaching MAX_LEN without last: len=MAX_LEN, pulse o_overflow_err, go to DRAIN.
  - DRAIN: o_usr_ready=1; accepted beats are discarded. On the beat with last=1, go to HDR.
  - HDR / CMD / LEN / PLD: emit HEAD_BYTE, cmd, len, then buffer[0..len-1] in order. o_usr_ready=0 in all of these.
  - DONE: single cycle; o_frame_done=1, o_usr_ready=0; returns to IDLE.
- Timing:
  - tvalid rises the cycle after the accepted last beat (or the cycle after the overflow beat, once DRAIN completes).
  - tdata/tlast are registered and held stable while tvalid=1 and tready=0.
  - tvalid never drops mid-frame.
  - Throughput is one byte per cycle while tready=1, so a 3+len frame with tready held high takes exactly 3+len cycles.
  - The buffer read path must support this (combinational read or prefetch).
- o_uart_DMA_tlast=1 only on the final frame byte. tvalid=0 the cycle after the final transfer (the DONE cycle).
- Back-to-back packets: the minimum gap from the last frame transfer to the next o_usr_ready=1 is 2 cycles (DONE, then IDLE).
- Beats presented while o_usr_ready=0 are not consumed; the upstream holds them.
- i_usr_cmd is ignored on every beat except the first accepted beat.

Optional Feature:
- UART_FRAME_CSUM_EN defined:
  - After the payload, one checksum byte is emitted: the 8-bit sum mod 256 of cmd, the length field and all payload bytes. tlast moves to this byte.
  - The length field = payload count + 1, so the receive framer's 3+len count covers the checksum.
  - The effective payload limit becomes MAX_LEN-1; truncation and o_overflow_err trigger at MAX_LEN-1 beats.
- Not defined: no checksum byte; the length field = payload count.

Test Plan:
- Reset values: hold i_rst_n=0 -> all outputs 0. Release, tready=1 -> o_usr_ready=1 next cycle, no tvalid.
- Basic frame: cmd=8'hA1, payload 11,22,33 (last on 33), tready=1 -> stream 55,A1,03,11,22,33 on 6 consecutive cycles, tlast on 33, done pulse the next cycle.
- Backpressure: same packet, toggle tready 1/0 per cycle -> identical byte sequence, data stable during stalls, no drops or duplicates.
- Single byte: cmd=8'h02, payload 7F with last on the first beat -> 55,02,01,7F; tvalid rises the cycle after the accept.
- Overflow: MAX_LEN=4, send 6 beats 01..06 with last on 06 -> overflow pulse on beat 4, beats 5–6 accepted and dropped, frame 55,cmd,04,01,02,03,04.
- With UART_FRAME_CSUM_EN: cmd=01, payload 10,20 -> 55,01,03,10,20,34 (01+03+10+20=34h). Also assert i_rst_n=0 mid-payload -> tvalid=0 immediately, and the next packet frames correctly.
